// File: rtl/vocoder_band_mixer.sv
// Vocoder band mixer: one shared multiplier folds NUM_BANDS gated carrier bands by their envelope gains.
// Optional MIXER_CLIP_CNT_EN adds a saturating clip_count output.
module vocoder_band_mixer #(
    parameter int NUM_BANDS = 15,
    parameter int OUT_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_44k,
    input  logic [NUM_BANDS*16-1:0] carrier_bands,
    input  logic [NUM_BANDS-1:0]    valid_bus,
    input  logic [NUM_BANDS*16-1:0] envelope,
    output logic signed [15:0]      mix_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
`ifdef MIXER_CLIP_CNT_EN
    ,
    output logic [15:0]             clip_count
`endif
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_BANDS);
    localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int SHIFT  = COEF_W + OUT_SHIFT;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_BANDS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic signed [DATA_W-1:0]   band_lat [NUM_BANDS];
    logic [COEF_W-1:0]          env_lat  [NUM_BANDS];

    logic signed [PROD_W-1:0]   band_ext;
    logic signed [PROD_W-1:0]   env_ext;
    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    shifted;

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return $signed(v[DATA_W-1:0]);
    endfunction

    function automatic logic is_clipped(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    // Envelope is unsigned Q0.16, so it gets a zero sign bit before the signed multiply.
    assign band_ext = PROD_W'(band_lat[idx]);
    assign env_ext  = $signed({{(PROD_W - COEF_W){1'b0}}, env_lat[idx]});
    assign product  = band_ext * env_ext;
    assign shifted  = acc >>> SHIFT;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            mix_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_BANDS; i++) begin
                band_lat[i] <= '0;
                env_lat[i]  <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            overrun   <= enable_44k && (state != IDLE);
            case (state)
                IDLE: begin
                    if (enable_44k) begin
                        for (int i = 0; i < NUM_BANDS; i++) begin
                            band_lat[i] <= valid_bus[i] ? $signed(carrier_bands[i*DATA_W +: DATA_W]) : '0;
                            env_lat[i]  <= envelope[i*COEF_W +: COEF_W];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(product);
                    idx <= idx + 1'b1;
                    if (idx == IDX_LAST)
                        state <= OUTPUT;
                end
                OUTPUT: begin
                    mix_out   <= saturate(shifted);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIXER_CLIP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            clip_count <= '0;
        else if ((state == OUTPUT) && is_clipped(shifted) && (clip_count != 16'hFFFF))
            clip_count <= clip_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vocoder_band_mixer.sv
// Scoreboard bench for vocoder_band_mixer: directed vectors push expected mixes, a monitor pops them on out_valid.
module tb_vocoder_band_mixer;

    localparam int NB = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable_44k;
    logic [NB*16-1:0]     carrier_bands;
    logic [NB-1:0]        valid_bus;
    logic [NB*16-1:0]     envelope;
    logic signed [15:0]   mix_out;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;
`ifdef MIXER_CLIP_CNT_EN
    logic [15:0]          clip_count;
    int                   exp_clip = 0;
`endif

    logic signed [15:0]   bands [NB];
    logic [15:0]          envs  [NB];

    typedef struct {
        logic signed [15:0] val;
        int                 issue;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   vcnt = 0;
    int   ov_cnt = 0;

    vocoder_band_mixer #(.NUM_BANDS(NB), .OUT_SHIFT(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_44k    (enable_44k),
        .carrier_bands (carrier_bands),
        .valid_bus     (valid_bus),
        .envelope      (envelope),
        .mix_out       (mix_out),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun)
`ifdef MIXER_CLIP_CNT_EN
        ,
        .clip_count    (clip_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        carrier_bands = '0;
        envelope      = '0;
        for (int i = 0; i < NB; i++) begin
            carrier_bands[i*16 +: 16] = bands[i];
            envelope[i*16 +: 16]      = envs[i];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per out_valid pulse.
    always @(negedge clk) begin
        if (overrun === 1'b1)
            ov_cnt++;
        if (out_valid === 1'b1) begin
            vcnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid got=%0d expected=no_output", mix_out);
            end else begin
                mon_e = sb.pop_front();
                chk("mix_out", mix_out, mon_e.val);
                chk("latency", cyc - mon_e.issue, NB + 1);
            end
        end
    end

    task automatic clear_vec();
        for (int i = 0; i < NB; i++) begin
            bands[i] = '0;
            envs[i]  = '0;
        end
        valid_bus = '0;
    endtask

    task automatic do_mix(input logic signed [15:0] exp_val);
        exp_t e;
        @(posedge clk); #1;
        enable_44k = 1'b1;
        e.val   = exp_val;
        e.issue = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        enable_44k = 1'b0;
        chk("busy_after_capture", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic check_clip();
`ifdef MIXER_CLIP_CNT_EN
        chk("clip_count", clip_count, exp_clip);
`endif
    endtask

    task automatic hold_test(input int hold);
        int v0, o0;
        exp_t e;
        clear_vec();
        bands[0] = 16'sd16384; envs[0] = 16'hFFFF; valid_bus[0] = 1'b1;
        v0 = vcnt; o0 = ov_cnt;
        do_mix(16'sd16383);
        repeat (NB) @(posedge clk);
        #1;
        enable_44k = 1'b1;
        @(posedge clk); #1;
        chk("overrun_on_output", overrun, 1);
        if (hold > 1) begin
            e.val   = 16'sd16383;
            e.issue = cyc + 1;
            sb.push_back(e);
            @(posedge clk); #1;
            enable_44k = 1'b0;
            chk("busy_restart", busy, 1);
        end else begin
            enable_44k = 1'b0;
        end
        wait_idle();
        chk("hold_overruns", ov_cnt - o0, 1);
        chk("hold_valids", vcnt - v0, (hold > 1) ? 2 : 1);
    endtask

    initial begin
        int v0, o0;
        rst = 1'b0;
        enable_44k = 1'b0;
        clear_vec();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mix_out", mix_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        check_clip();
        rst = 1'b1;
        @(posedge clk); #1;

        // Single band at half scale with full gain; band 5 is masked off.
        clear_vec();
        bands[0] = 16'sd16384; envs[0] = 16'hFFFF; valid_bus[0] = 1'b1;
        bands[5] = 16'sd12345; envs[5] = 16'hFFFF;
        do_mix(16'sd16383);
        wait_idle();

        clear_vec();
        bands[3] = 16'sd1000; envs[3] = 16'h8000;
        do_mix(16'sd0);
        wait_idle();
        valid_bus[3] = 1'b1;
        do_mix(16'sd500);
        wait_idle();

        clear_vec();
        bands[0] = -16'sd1; envs[0] = 16'h0001; valid_bus[0] = 1'b1;
        do_mix(-16'sd1);
        wait_idle();

        // 100*65535 - 50*32768 = 4915100 -> floor(/65536) = 74
        clear_vec();
        bands[0] = 16'sd100; envs[0] = 16'hFFFF;
        bands[1] = -16'sd50; envs[1] = 16'h8000;
        valid_bus = 15'b000_0000_0000_0011;
        do_mix(16'sd74);
        wait_idle();
        check_clip();

        for (int i = 0; i < NB; i++) begin
            bands[i] = 16'sd32767; envs[i] = 16'hFFFF;
        end
        valid_bus = '1;
        do_mix(16'sd32767);
        wait_idle();
`ifdef MIXER_CLIP_CNT_EN
        exp_clip = 1;
`endif
        check_clip();

        for (int i = 0; i < NB; i++) begin
            bands[i] = -16'sd32768; envs[i] = 16'h8000;
        end
        do_mix(-16'sd32768);
        wait_idle();
`ifdef MIXER_CLIP_CNT_EN
        exp_clip = 2;
`endif
        check_clip();

        for (int i = 0; i < NB; i++) begin
            bands[i] = 16'sd1234; envs[i] = 16'hFFFF;
        end
        valid_bus = '0;
        do_mix(16'sd0);
        wait_idle();
        check_clip();

        // Second strobe mid-mix with changed inputs must not disturb the first result.
        clear_vec();
        bands[3] = 16'sd1000; envs[3] = 16'h8000; valid_bus[3] = 1'b1;
        v0 = vcnt; o0 = ov_cnt;
        do_mix(16'sd500);
        repeat (4) @(posedge clk);
        #1;
        bands[3] = 16'sd3000; envs[3] = 16'hFFFF;
        enable_44k = 1'b1;
        @(posedge clk); #1;
        enable_44k = 1'b0;
        chk("overrun_pulse", overrun, 1);
        @(posedge clk); #1;
        chk("overrun_single", overrun, 0);
        wait_idle();
        chk("overrun_count", ov_cnt - o0, 1);
        chk("overrun_valids", vcnt - v0, 1);

        hold_test(2);
        hold_test(1);

        // Reset in the middle of ACCUM aborts the mix.
        clear_vec();
        bands[0] = -16'sd1000; envs[0] = 16'h8000; valid_bus[0] = 1'b1;
        v0 = vcnt;
        @(posedge clk); #1;
        enable_44k = 1'b1;
        @(posedge clk); #1;
        enable_44k = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_mix_out", mix_out, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
`ifdef MIXER_CLIP_CNT_EN
        exp_clip = 0;
`endif
        check_clip();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_valid", vcnt - v0, 0);
        do_mix(-16'sd500);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vocoder_band_mixer.md
VOCODER_BAND_MIXER -- requirements
Module: vocoder_band_mixer

Interface
REQ-001 Parameter NUM_BANDS, default 15: number of carrier bands mixed per sample.
REQ-002 Parameter OUT_SHIFT, default 0: extra arithmetic right shift applied before saturation.
REQ-003 clk  input  1  system clock; every register is clocked on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low: assertion (0) resets at once, release is synchronous to clk.
REQ-005 enable_44k  input  1  one-cycle sample strobe, the same strobe that drives the carrier playback bank.
REQ-006 carrier_bands  input  NUM_BANDS x 16 signed  carrier band samples from the playback bank.
REQ-007 valid_bus  input  NUM_BANDS  per-band valid flags from the playback bank.
REQ-008 envelope  input  NUM_BANDS x 16 unsigned  modulator envelope gains, Q0.16 format.
REQ-009 mix_out  output  16 signed  mixed, saturated vocoder sample.
REQ-010 out_valid  output  1  one-cycle pulse; mix_out is new in that cycle.
REQ-011 busy  output  1  high while a mix is in progress.
REQ-012 overrun  output  1  one-cycle pulse when an enable_44k strobe arrives while busy.

Function
REQ-013 FSM states: IDLE, ACCUM, OUTPUT; reset state is IDLE.
REQ-014 In IDLE, enable_44k=1 at edge N captures all inputs:
 - band i is latched from carrier_bands[i] if valid_bus[i]=1, else latched as 0.
 - envelope[i] is latched unchanged.
 - accumulator is cleared, band index is set to 0, FSM goes to ACCUM.
REQ-015 In ACCUM, the block runs one multiply-accumulate per cycle using a single shared multiplier: acc += latched_band[idx] * latched_env[idx].
REQ-016 Each product is signed 16 x unsigned 16, giving 33 bits signed; the accumulator is 33 + ceil(log2(NUM_BANDS)) bits (37 bits at the default) and can never overflow.
REQ-017 ACCUM lasts exactly NUM_BANDS cycles (edges N+1 to N+NUM_BANDS), then the FSM goes to OUTPUT.
REQ-018 In OUTPUT, at edge N+NUM_BANDS+1:
 - result = acc >>> (16 + OUT_SHIFT), arithmetic shift.
 - result is saturated to the range [-32768, +32767] and registered into mix_out.
 - out_valid=1 for exactly that one cycle.
 - FSM returns to IDLE.
REQ-019 Latency from the enable_44k edge to out_valid is NUM_BANDS+1 cycles (16 at the default); mix_out holds its value until the next OUTPUT.
REQ-020 busy=1 in ACCUM and OUTPUT, and 0 in IDLE.
REQ-021 enable_44k=1 in ACCUM or OUTPUT: the strobe is ignored, overrun pulses for 1 cycle, and the mix in progress is not disturbed.
REQ-022 enable_44k=1 in the same cycle the FSM enters IDLE from OUTPUT: the strobe is accepted as a normal IDLE start at the next edge only if still high; a single-cycle strobe falling on the OUTPUT cycle counts as overrun.
REQ-023 Input changes after the capture edge have no effect on the mix in progress.
REQ-024 An all-zero valid_bus gives mix_out=0 with normal timing.

Reset
REQ-025 While rst=0: FSM=IDLE, mix_out=0, out_valid=0, busy=0, overrun=0, accumulator=0, index=0, latches=0.
REQ-026 Reset asserted mid-ACCUM aborts the mix; no out_valid is produced for that sample.

Configuration
REQ-027 Macro MIXER_CLIP_CNT_EN.
 - When defined: adds output clip_count (16 bits, unsigned), which increments by 1 for each OUTPUT in which saturation occurred, saturates at 65535, and resets to 0.
 - When undefined: the port and its logic are absent and all other behaviour is identical.

Verification
REQ-028 Band 0 = +16384, envelope[0] = 0xFFFF, all other valid bits 0, strobe -> out_valid 16 cycles later, mix_out=16383.
REQ-029 All bands = +32767, valid_bus all 1, all envelopes = 0xFFFF -> mix_out=+32767 (saturated); clip_count 0->1 when the macro is defined.
REQ-030 All bands = -32768, valid_bus all 1, all envelopes = 0x8000 -> mix_out=-32768 (saturated).
REQ-031 Band 3 = +1000, envelope[3] = 0x8000, valid_bus[3]=0 -> mix_out=0; same stimulus with valid_bus[3]=1 -> mix_out=500.
REQ-032 Second strobe 5 cycles after the first -> overrun pulses once, the first result is unchanged, exactly one out_valid is produced.
REQ-033 rst driven to 0 at cycle 8 of ACCUM -> all outputs read 0 immediately, no out_valid, and the next strobe after release mixes correctly.
